// File: rtl/sad_disparity_core.sv
// Stereo SAD disparity core: 5x5 left/right windows in, winner-take-all
// disparity, its cost and a gray-level display value out.
// Stages: input capture -> per-row sums -> masked SAD -> argmin.
module sad_disparity_core #(
  parameter int MAX_DISP  = 16,
  parameter int IMG_WIDTH = 640,
  localparam int DISP_W   = $clog2(MAX_DISP)
) (
  input  logic              i_clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [39:0]       vector_l_1,
  input  logic [39:0]       vector_l_2,
  input  logic [39:0]       vector_l_3,
  input  logic [39:0]       vector_l_4,
  input  logic [39:0]       vector_l_5,
  input  logic [39:0]       vector_r_1,
  input  logic [39:0]       vector_r_2,
  input  logic [39:0]       vector_r_3,
  input  logic [39:0]       vector_r_4,
  input  logic [39:0]       vector_r_5,
  output logic              o_valid,
  output logic [DISP_W-1:0] o_disp,
  output logic [7:0]        o_gray,
  output logic [12:0]       o_cost,
  output logic              o_row_end
);

  localparam int               COL_W     = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IMG_WIDTH - 1);
  localparam int               GRAY_SH   = 8 - DISP_W;
  localparam logic [12:0]      COST_MASK = 13'h1FFF;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    if (a >= b) r = a - b;
    else        r = b - a;
    return r;
  endfunction

  function automatic logic [10:0] row_sad(input logic [39:0] a, input logic [39:0] b);
    logic [10:0] acc;
    acc = 11'd0;
    for (int k = 0; k < 5; k++) acc = acc + {3'd0, abs_diff(a[8*k +: 8], b[8*k +: 8])};
    return acc;
  endfunction

  function automatic logic [12:0] sum5(input logic [4:0][10:0] s);
    logic [12:0] acc;
    acc = 13'd0;
    for (int k = 0; k < 5; k++) acc = acc + {2'd0, s[k]};
    return acc;
  endfunction

  logic [4:0][39:0]  cur_l_s;
  logic [4:0][39:0]  cur_r_s;
  logic [COL_W-1:0]  col_r;
  // Capture stage; hist_r[0] holds the window captured with it, so d uses hist_r[d].
  logic              s0_valid_r;
  logic [COL_W-1:0]  s0_col_r;
  logic              s0_row_end_r;
  logic [4:0][39:0]  s0_left_r;
  logic [4:0][39:0]  hist_r [MAX_DISP];
  logic              s1_valid_r;
  logic [COL_W-1:0]  s1_col_r;
  logic              s1_row_end_r;
  logic [4:0][10:0]  s1_sum_r [MAX_DISP];
  logic [MAX_DISP-1:0] d_ok_s;
  logic              s2_valid_r;
  logic              s2_row_end_r;
  logic [12:0]       s2_cost_r [MAX_DISP];
  logic [12:0]       best_cost_s;
  logic [DISP_W-1:0] best_idx_s;

  assign cur_l_s = {vector_l_5, vector_l_4, vector_l_3, vector_l_2, vector_l_1};
  assign cur_r_s = {vector_r_5, vector_r_4, vector_r_3, vector_r_2, vector_r_1};

  // Column counter: advances per valid window, wraps at end of row.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)                           col_r <= '0;
    else if (i_valid && col_r == COL_MAX) col_r <= '0;
    else if (i_valid)                     col_r <= col_r + COL_W'(1);
    else                                  col_r <= col_r;
  end

  // Capture stage: left window plus column tag of each valid input.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_r   <= 1'b0;
      s0_col_r     <= '0;
      s0_row_end_r <= 1'b0;
      s0_left_r    <= '0;
    end else begin
      s0_valid_r <= i_valid;
      if (i_valid) begin
        s0_col_r     <= col_r;
        s0_row_end_r <= (col_r == COL_MAX);
        s0_left_r    <= cur_l_s;
      end
    end
  end

  // Right-window history shift register, advanced only by valid inputs.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_DISP; k++) hist_r[k] <= '0;
    end else if (i_valid) begin
      hist_r[0] <= cur_r_s;
      for (int k = 1; k < MAX_DISP; k++) hist_r[k] <= hist_r[k-1];
    end
  end

  // S1: per-candidate, per-row sums of absolute differences.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_col_r     <= '0;
      s1_row_end_r <= 1'b0;
      for (int d = 0; d < MAX_DISP; d++) s1_sum_r[d] <= '0;
    end else begin
      s1_valid_r <= s0_valid_r;
      if (s0_valid_r) begin
        s1_col_r     <= s0_col_r;
        s1_row_end_r <= s0_row_end_r;
        for (int d = 0; d < MAX_DISP; d++)
          for (int r = 0; r < 5; r++)
            s1_sum_r[d][r] <= row_sad(s0_left_r[r], hist_r[d][r]);
      end
    end
  end

  // A candidate is usable only once the row holds d earlier windows.
  for (genvar d = 0; d < MAX_DISP; d++) begin : g_dok
    assign d_ok_s[d] = (COL_W'(d) <= s1_col_r);
  end

  // S2: full SAD per candidate, unusable candidates forced to the sentinel.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r   <= 1'b0;
      s2_row_end_r <= 1'b0;
      for (int d = 0; d < MAX_DISP; d++) s2_cost_r[d] <= '0;
    end else begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_row_end_r <= s1_row_end_r;
        for (int d = 0; d < MAX_DISP; d++)
          s2_cost_r[d] <= d_ok_s[d] ? sum5(s1_sum_r[d]) : COST_MASK;
      end
    end
  end

  // Argmin with strict compare so ties resolve to the smallest disparity.
  always_comb begin
    best_cost_s = s2_cost_r[0];
    best_idx_s  = '0;
    for (int d = 1; d < MAX_DISP; d++) begin
      if (s2_cost_r[d] < best_cost_s) begin
        best_cost_s = s2_cost_r[d];
        best_idx_s  = DISP_W'(d);
      end else begin
        best_cost_s = best_cost_s;
        best_idx_s  = best_idx_s;
      end
    end
  end

  // S3: output registers; data holds while no result is presented.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid   <= 1'b0;
      o_disp    <= '0;
      o_gray    <= 8'd0;
      o_cost    <= 13'd0;
      o_row_end <= 1'b0;
    end else begin
      o_valid   <= s2_valid_r;
      o_row_end <= s2_valid_r & s2_row_end_r;
      if (s2_valid_r) begin
        o_disp <= best_idx_s;
        o_gray <= {best_idx_s, {GRAY_SH{1'b0}}};
        o_cost <= best_cost_s;
      end
    end
  end

endmodule

// File: tb/tb_sad_disparity_core.sv
// Scoreboard bench for sad_disparity_core: a column-indexed image model
// predicts each result; a negedge monitor compares whenever o_valid shows.
module tb_sad_disparity_core;

  localparam int MAX_DISP  = 16;
  localparam int IMG_WIDTH = 640;
  localparam int DISP_W    = 4;
  localparam int SENT      = 8191;

  logic              i_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic [39:0]       vl1 = '0, vl2 = '0, vl3 = '0, vl4 = '0, vl5 = '0;
  logic [39:0]       vr1 = '0, vr2 = '0, vr3 = '0, vr4 = '0, vr5 = '0;
  logic              o_valid;
  logic [DISP_W-1:0] o_disp;
  logic [7:0]        o_gray;
  logic [12:0]       o_cost;
  logic              o_row_end;

  sad_disparity_core #(.MAX_DISP(MAX_DISP), .IMG_WIDTH(IMG_WIDTH)) dut (
    .i_clk(i_clk), .rst_n(rst_n), .i_valid(i_valid),
    .vector_l_1(vl1), .vector_l_2(vl2), .vector_l_3(vl3), .vector_l_4(vl4), .vector_l_5(vl5),
    .vector_r_1(vr1), .vector_r_2(vr2), .vector_r_3(vr3), .vector_r_4(vr4), .vector_r_5(vr5),
    .o_valid(o_valid), .o_disp(o_disp), .o_gray(o_gray), .o_cost(o_cost), .o_row_end(o_row_end)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int due;
    int disp;
    int cost;
    int row_end;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          mcol = 0;
  logic [199:0] rrow [IMG_WIDTH];
  int          last_disp = 0, last_gray = 0, last_cost = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [199:0] rnd200();
    logic [223:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[199:0];
  endfunction

  function automatic int sad(input logic [199:0] l, input logic [199:0] r);
    int s, a, b;
    s = 0;
    for (int k = 0; k < 25; k++) begin
      a = int'(l[8*k +: 8]);
      b = int'(r[8*k +: 8]);
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  // One input cycle; valid inputs get their expected result queued.
  task automatic drive(input bit v, input logic [199:0] l, input logic [199:0] r);
    exp_t e;
    int   c;
    @(posedge i_clk);
    #2;
    i_valid = v;
    {vl5, vl4, vl3, vl2, vl1} = l;
    {vr5, vr4, vr3, vr2, vr1} = r;
    if (v) begin
      rrow[mcol] = r;
      e.due = cyc + 4;
      e.disp = 0;
      e.cost = sad(l, r);
      for (int d = 1; d < MAX_DISP; d++) begin
        c = (d <= mcol) ? sad(l, rrow[mcol - d]) : SENT;
        if (c < e.cost) begin
          e.cost = c;
          e.disp = d;
        end
      end
      e.row_end = (mcol == IMG_WIDTH - 1) ? 1 : 0;
      q.push_back(e);
      mcol = (mcol == IMG_WIDTH - 1) ? 0 : mcol + 1;
    end
  endtask

  // Shifted scene: left window at column c equals right window at c-5.
  task automatic drive_shift(input bit v);
    logic [199:0] l, r;
    r = rnd200();
    l = (mcol >= 5) ? rrow[mcol - 5] : rnd200();
    drive(v, l, r);
  endtask

  task automatic check_zero_outputs();
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_disp", int'(o_disp), 0);
    chk("rst_o_gray", int'(o_gray), 0);
    chk("rst_o_cost", int'(o_cost), 0);
    chk("rst_o_row_end", int'(o_row_end), 0);
  endtask

  // Monitor: pops the scoreboard on every presented result.
  always @(negedge i_clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_o_valid", int'(o_valid), 0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc, e.due);
          chk("o_disp", int'(o_disp), e.disp);
          chk("o_gray", int'(o_gray), e.disp * (256 / MAX_DISP));
          chk("o_cost", int'(o_cost), e.cost);
          chk("o_row_end", int'(o_row_end), e.row_end);
          last_disp = e.disp;
          last_gray = e.disp * (256 / MAX_DISP);
          last_cost = e.cost;
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("missing_o_valid", int'(o_valid), 1);
      end else begin
        chk("hold_disp", int'(o_disp), last_disp);
        chk("hold_gray", int'(o_gray), last_gray);
        chk("hold_cost", int'(o_cost), last_cost);
        chk("idle_row_end", int'(o_row_end), 0);
      end
    end
  end

  initial begin : stim
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int nvalid;
    logic [199:0] w;
    logic [199:0] ones;
    ones = '1;

    // Power-on reset
    repeat (3) @(posedge i_clk);
    #1;
    check_zero_outputs();
    #1;
    rst_n = 1'b1;
    repeat (4) drive(1'b0, '0, '0);

    // Identical images over a full row: disparity 0, cost 0
    for (int i = 0; i < IMG_WIDTH; i++) begin
      w = rnd200();
      drive(1'b1, w, w);
    end
    repeat (3) drive(1'b0, '0, '0);

    // Gap pattern, then a shifted textured scene across a row wrap
    for (int i = 0; i < 7; i++) drive_shift(pat[i] != 0);
    nvalid = 4;
    while (nvalid < IMG_WIDTH + 20) begin
      if ($urandom_range(5) == 0) begin
        drive_shift(1'b0);
      end else begin
        drive_shift(1'b1);
        nvalid++;
      end
    end
    repeat (3) drive(1'b0, '0, '0);

    // Flat inputs: all-zero tie, then maximal cost
    repeat (8) drive(1'b1, '0, '0);
    repeat (8) drive(1'b1, ones, '0);
    repeat (5) drive_shift(1'b1);

    // Reset mid-stream with i_valid high discards in-flight results
    @(posedge i_clk);
    #2;
    rst_n = 1'b0;
    i_valid = 1'b1;
    q.delete();
    mcol = 0;
    last_disp = 0;
    last_gray = 0;
    last_cost = 0;
    #1;
    check_zero_outputs();
    repeat (2) @(posedge i_clk);
    #2;
    rst_n = 1'b1;
    i_valid = 1'b0;
    repeat (4) drive(1'b0, '0, '0);

    // Restart of a row after reset
    repeat (30) drive_shift(1'b1);
    repeat (10) drive(1'b0, '0, '0);
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
